// File: rtl/sram_arbiter_pkg.sv
// Shared types and helpers for the external SRAM arbiter.
//   arb_state_t     : access sequencer states
//   ARB_CLIENT_*    : client slot assignment used by zx_ula
//   rr_pick()       : priority + round-robin winner selection
//   rr_next()       : round-robin pointer advance (wraps N-1 -> 1)
package sram_arbiter_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_TURN} arb_state_t;

  // Client indices and widths are sized for the largest supported arbiter.
  localparam int ARB_MAX_CLIENTS = 8;
  localparam int ARB_IDX_W       = 3;

  localparam int ARB_CLIENT_SCREEN = 0;
  localparam int ARB_CLIENT_CPU    = 1;
  localparam int ARB_CLIENT_UP     = 2;
  localparam int ARB_CLIENT_INIT   = 3;

  // Client 0 always wins. Otherwise, with rr_mode clear the lowest index
  // wins; with rr_mode set the search starts at ptr and wraps within 1..N-1.
  function automatic logic [ARB_IDX_W-1:0] rr_pick(
    input logic [ARB_MAX_CLIENTS-1:0] req,
    input logic [ARB_IDX_W-1:0]       ptr,
    input int                         nclients,
    input logic                       rr_mode
  );
    logic [ARB_IDX_W-1:0] win;
    logic [ARB_IDX_W-1:0] idx;
    logic                 found;
    int                   base;
    int                   slot;
    win   = '0;
    idx   = '0;
    found = 1'b0;
    slot  = 0;
    // A zero pointer never occurs in operation; treat it as pointing at 1.
    base  = (ptr == '0) ? 0 : int'(ptr) - 1;
    if (req[0]) begin
      win   = '0;
      found = 1'b1;
    end else if (!rr_mode) begin
      for (int i = 1; i < ARB_MAX_CLIENTS; i++) begin
        if (!found && i < nclients && req[i]) begin
          win   = ARB_IDX_W'(i);
          found = 1'b1;
        end
      end
    end else begin
      for (int k = 0; k < ARB_MAX_CLIENTS - 1; k++) begin
        if (!found && k < nclients - 1) begin
          slot = (base + k) % (nclients - 1) + 1;
          idx  = ARB_IDX_W'(slot);
          if (req[idx]) begin
            win   = idx;
            found = 1'b1;
          end
        end
      end
    end
    return win;
  endfunction

  function automatic logic [ARB_IDX_W-1:0] rr_next(
    input logic [ARB_IDX_W-1:0] win,
    input int                   nclients
  );
    if (int'(win) >= nclients - 1) return ARB_IDX_W'(1);
    return win + ARB_IDX_W'(1);
  endfunction

endpackage

// File: rtl/arb_rr_picker.sv
// Combinational winner selection for the SRAM arbiter.
//   req_i     : per-client request levels
//   ptr_i     : current round-robin pointer (1..NCLIENTS-1)
//   any_o     : at least one request present
//   win_o     : winning client index
//   ptr_nxt_o : pointer to adopt if this pick is granted
module arb_rr_picker
  import sram_arbiter_pkg::*;
#(
  parameter int NCLIENTS = 4,
  parameter int RR_MODE  = 1
) (
  input  logic [NCLIENTS-1:0]  req_i,
  input  logic [ARB_IDX_W-1:0] ptr_i,
  output logic                 any_o,
  output logic [ARB_IDX_W-1:0] win_o,
  output logic [ARB_IDX_W-1:0] ptr_nxt_o
);

  logic [ARB_MAX_CLIENTS-1:0] req_ext;

  always_comb begin
    req_ext                 = '0;
    req_ext[NCLIENTS-1:0]   = req_i;
    any_o                   = |req_i;
    win_o                   = rr_pick(req_ext, ptr_i, NCLIENTS, RR_MODE != 0);
    ptr_nxt_o               = ptr_i;
    // Client 0 bypasses the rotation, so its grants leave the pointer alone.
    if (RR_MODE != 0 && any_o && win_o != '0) begin
      ptr_nxt_o = rr_next(win_o, NCLIENTS);
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// N-client external SRAM access sequencer. Every output is registered so
// no request can reach the SRAM pins combinationally; the tristate buffer
// itself lives in the top level, driven by sram_doe/sram_dout.
//   clk28, rst                 : clock, synchronous active-high reset
//   req, we, addr, wdata       : per-client request, write flag, packed addr/data
//   ack, rdata                 : one-hot completion pulse, read data with ack
//   busy                       : high during ACCESS and TURN
//   sram_din                   : data sampled from the SRAM data bus
//   sram_a, sram_dout          : SRAM address and write data
//   sram_doe                   : data bus drive enable
//   sram_n_rd, sram_n_wr       : active-low strobes
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int NCLIENTS   = 4,
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 8,
  parameter int ACC_CYCLES = 2,
  parameter int RR_MODE    = 1
) (
  input  logic                       clk28,
  input  logic                       rst,
  input  logic [NCLIENTS-1:0]        req,
  input  logic [NCLIENTS-1:0]        we,
  input  logic [NCLIENTS*ADDR_W-1:0] addr,
  input  logic [NCLIENTS*DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0]          sram_din,
  output logic [NCLIENTS-1:0]        ack,
  output logic [DATA_W-1:0]          rdata,
  output logic                       busy,
  output logic [ADDR_W-1:0]          sram_a,
  output logic [DATA_W-1:0]          sram_dout,
  output logic                       sram_doe,
  output logic                       sram_n_rd,
  output logic                       sram_n_wr
);

  localparam logic [2:0] CNT_LAST = 3'(ACC_CYCLES - 1);

  arb_state_t           state_q;
  logic [2:0]           cnt_q;
  logic [ARB_IDX_W-1:0] win_q;
  logic [ARB_IDX_W-1:0] ptr_q;
  logic                 we_q;
  logic [NCLIENTS-1:0]  ack_q;
  logic [DATA_W-1:0]    rdata_q;
  logic                 busy_q;
  logic [ADDR_W-1:0]    sram_a_q;
  logic [DATA_W-1:0]    sram_dout_q;
  logic                 sram_doe_q;
  logic                 sram_n_rd_q;
  logic                 sram_n_wr_q;

  logic                 any_d;
  logic [ARB_IDX_W-1:0] win_d;
  logic [ARB_IDX_W-1:0] ptr_d;
  logic                 we_d;
  logic [ADDR_W-1:0]    addr_d;
  logic [DATA_W-1:0]    wdata_d;
  logic [NCLIENTS-1:0]  win_oh;

  arb_rr_picker #(
    .NCLIENTS (NCLIENTS),
    .RR_MODE  (RR_MODE)
  ) u_picker (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .any_o     (any_d),
    .win_o     (win_d),
    .ptr_nxt_o (ptr_d)
  );

  // Pick the winner's operands out of the packed client buses.
  always_comb begin
    we_d    = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    for (int i = 0; i < NCLIENTS; i++) begin
      if (win_d == ARB_IDX_W'(i)) begin
        we_d    = we[i];
        addr_d  = addr[i*ADDR_W +: ADDR_W];
        wdata_d = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    win_oh = '0;
    for (int i = 0; i < NCLIENTS; i++) begin
      win_oh[i] = (win_q == ARB_IDX_W'(i));
    end
  end

  // Strobe/enable values are set one edge ahead so that each register
  // already holds the level the following cycle needs.
  always_ff @(posedge clk28) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      cnt_q       <= '0;
      win_q       <= '0;
      ptr_q       <= ARB_IDX_W'(1);
      we_q        <= 1'b0;
      ack_q       <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      sram_a_q    <= '0;
      sram_dout_q <= '0;
      sram_doe_q  <= 1'b0;
      sram_n_rd_q <= 1'b1;
      sram_n_wr_q <= 1'b1;
    end else begin
      ack_q <= '0;
      unique case (state_q)
        ARB_IDLE: begin
          if (any_d) begin
            state_q  <= ARB_ACCESS;
            cnt_q    <= '0;
            win_q    <= win_d;
            ptr_q    <= ptr_d;
            we_q     <= we_d;
            busy_q   <= 1'b1;
            sram_a_q <= addr_d;
            if (we_d) begin
              // Cycle 0 of a write is address setup: drive data, no strobe.
              sram_dout_q <= wdata_d;
              sram_doe_q  <= 1'b1;
            end else begin
              sram_n_rd_q <= 1'b0;
            end
          end
        end
        ARB_ACCESS: begin
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == CNT_LAST) begin
            ack_q <= win_oh;
            if (we_q) begin
              // Keep driving data through TURN for hold time.
              sram_n_wr_q <= 1'b1;
              state_q     <= ARB_TURN;
            end else begin
              // The ack cycle is IDLE, so a pending request is granted there.
              sram_n_rd_q <= 1'b1;
              rdata_q     <= sram_din;
              busy_q      <= 1'b0;
              state_q     <= ARB_IDLE;
            end
          end else if (we_q) begin
            sram_n_wr_q <= 1'b0;
          end
        end
        ARB_TURN: begin
          sram_doe_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= ARB_IDLE;
        end
        default: begin
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign sram_a    = sram_a_q;
  assign sram_dout = sram_dout_q;
  assign sram_doe  = sram_doe_q;
  assign sram_n_rd = sram_n_rd_q;
  assign sram_n_wr = sram_n_wr_q;

endmodule
